mpu_load: RTL and testbench

MPU_LOAD -- requirements
Module: mpu_load

---
 rtl/mpu_load.sv | 119 +++++++++++
 tb/tb_mpu_load.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mpu_load.sv
// Matrix load engine: streams a row-major M x N float matrix from memory into one
// matrix register, one element per accepted memory beat, with a one-cycle done pulse.
package global_defs;
    localparam int FPBITS          = 31;
    localparam int MBITS           = 3;
    localparam int NBITS           = 3;
    localparam int MATRIX_REG_BITS = 2;
endpackage

package mpu_pkg;
    typedef enum logic [1:0] {LOAD_IDLE, LOAD_MATRIX, LOAD_DONE} load_state_t;
endpackage

module mpu_load
    import global_defs::*;
    import mpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en_in,
    input  logic [MATRIX_REG_BITS:0]   mem_load_addr_in,
    input  logic [MBITS:0]             mem_m_load_size_in,
    input  logic [NBITS:0]             mem_n_load_size_in,
    input  logic                       mem_load_valid_in,
    input  logic [FPBITS:0]            mem_load_element_in,
    output logic                       mem_load_ack_out,
    output logic                       reg_load_en_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [FPBITS:0]            reg_load_element_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output logic                       load_busy_out,
    output logic                       load_done_out
);

    load_state_t              state_q, state_d;
    logic [MATRIX_REG_BITS:0] addr_q;
    logic [MBITS:0]           m_q, row_ptr;
    logic [NBITS:0]           n_q, col_ptr;
    logic                     start, accept, last_col, last_elem;

    assign start     = (state_q == LOAD_IDLE) && load_en_in;
    assign accept    = mem_load_ack_out && mem_load_valid_in;
    assign last_col  = (col_ptr == n_q - (NBITS+1)'(1));
    assign last_elem = last_col && (row_ptr == m_q - (MBITS+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        mem_load_ack_out = 1'b0;
        load_busy_out    = 1'b0;
        load_done_out    = 1'b0;
        case (state_q)
            LOAD_IDLE: begin
                if (load_en_in)
                    state_d = (mem_m_load_size_in == '0 || mem_n_load_size_in == '0)
                              ? LOAD_DONE : LOAD_MATRIX;
            end
            LOAD_MATRIX: begin
                mem_load_ack_out = 1'b1;
                load_busy_out    = 1'b1;
                if (accept && last_elem) state_d = LOAD_DONE;
            end
            LOAD_DONE: begin
                load_busy_out = 1'b1;
                load_done_out = 1'b1;
                state_d       = LOAD_IDLE;
            end
            default: state_d = LOAD_IDLE;
        endcase
    end

    // Write port is registered one edge behind the accept, so the final write lands
    // in the same cycle the FSM sits in LOAD_DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q               <= '0;
            m_q                  <= '0;
            n_q                  <= '0;
            row_ptr              <= '0;
            col_ptr              <= '0;
            reg_load_en_out      <= 1'b0;
            reg_i_load_loc_out   <= '0;
            reg_j_load_loc_out   <= '0;
            reg_load_element_out <= '0;
        end else begin
            reg_load_en_out <= accept;
            if (start) begin
                addr_q  <= mem_load_addr_in;
                m_q     <= mem_m_load_size_in;
                n_q     <= mem_n_load_size_in;
                row_ptr <= '0;
                col_ptr <= '0;
            end
            if (accept) begin
                reg_i_load_loc_out   <= row_ptr;
                reg_j_load_loc_out   <= col_ptr;
                reg_load_element_out <= mem_load_element_in;
                if (last_col) begin
                    col_ptr <= '0;
                    row_ptr <= row_ptr + (MBITS+1)'(1);
                end else begin
                    col_ptr <= col_ptr + (NBITS+1)'(1);
                end
            end
        end
    end

    assign reg_load_addr_out   = addr_q;
    assign reg_m_load_size_out = m_q;
    assign reg_n_load_size_out = n_q;

endmodule

// File: tb/tb_mpu_load.sv
// Directed bench for mpu_load: each task drives one scenario and checks a packed
// snapshot of all outputs against hand-derived values.
module tb_mpu_load;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [2:0]  addr;
    logic [3:0]  msz, nsz;
    logic        valid;
    logic [31:0] elem;
    logic        ack, wr_en, busy, done;
    logic [2:0]  wr_addr;
    logic [3:0]  wi, wj, msize, nsize;
    logic [31:0] welem;
    logic [54:0] obs, exp;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mpu_load dut (
        .clk(clk), .rst(rst), .load_en_in(load_en),
        .mem_load_addr_in(addr), .mem_m_load_size_in(msz), .mem_n_load_size_in(nsz),
        .mem_load_valid_in(valid), .mem_load_element_in(elem),
        .mem_load_ack_out(ack), .reg_load_en_out(wr_en), .reg_load_addr_out(wr_addr),
        .reg_i_load_loc_out(wi), .reg_j_load_loc_out(wj), .reg_load_element_out(welem),
        .reg_m_load_size_out(msize), .reg_n_load_size_out(nsize),
        .load_busy_out(busy), .load_done_out(done)
    );

    // {wr_en, addr, i, j, element, done, busy, ack, m, n}
    assign obs = {wr_en, wr_addr, wi, wj, welem, done, busy, ack, msize, nsize};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 0; addr = 0; msz = 0; nsz = 0; valid = 0; elem = 0;
        #1;
        n_cmp++; if (obs !== 55'd0) begin n_err++; $display("FAIL reset_async: got %h want %h", obs, 55'd0); end
        tick();
        n_cmp++; if (obs !== 55'd0) begin n_err++; $display("FAIL reset_clocked: got %h want %h", obs, 55'd0); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk); load_en = 1; addr = 1; msz = 2; nsz = 3; valid = 1; elem = 32'hFF;
        tick(); load_en = 0;
        exp = {1'b0, 3'd1, 4'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd3};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL basic_start: got %h want %h", obs, exp); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); elem = 32'h100 + k;
            tick();
            exp = {1'b1, 3'd1, 4'(k/3), 4'(k%3), 32'(32'h100 + k), (k == 5), 1'b1, (k != 5), 4'd2, 4'd3};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL basic_write%0d: got %h want %h", k, obs, exp); end
        end
        @(negedge clk); valid = 0;
        tick();
        exp = {1'b0, 3'd1, 4'd1, 4'd2, 32'h105, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL basic_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_stall();
        int kk;
        @(negedge clk); load_en = 1; addr = 2; msz = 2; nsz = 2; valid = 0;
        tick(); load_en = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); valid = (c % 2 == 0); elem = 200 + c;
            tick();
            kk  = c / 2;
            exp = {(c % 2 == 0), 3'd2, 4'(kk/2), 4'(kk%2), 32'(200 + 2*kk),
                   (c == 6), (c != 7), !(c == 6 || c == 7), 4'd2, 4'd2};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL stall_c%0d: got %h want %h", c, obs, exp); end
        end
        valid = 0;
    endtask

    task automatic test_zero();
        @(negedge clk); load_en = 1; addr = 0; msz = 0; nsz = 3; valid = 1; elem = 32'hDEAD;
        tick(); load_en = 0;
        exp = {1'b0, 3'd0, 4'd1, 4'd1, 32'd206, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL zero_done: got %h want %h", obs, exp); end
        tick();
        exp = {1'b0, 3'd0, 4'd1, 4'd1, 32'd206, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL zero_idle: got %h want %h", obs, exp); end
        valid = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); load_en = 1; addr = 3; msz = 3; nsz = 3; valid = 1; elem = 300;
        tick(); load_en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); elem = 300 + k;
            tick();
        end
        exp = {1'b1, 3'd3, 4'd0, 4'd2, 32'd302, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mid_before: got %h want %h", obs, exp); end
        #2; rst = 1'b1; #1;
        n_cmp++; if (obs !== 55'd0) begin n_err++; $display("FAIL mid_reset: got %h want %h", obs, 55'd0); end
        valid = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); load_en = 1; addr = 1; msz = 1; nsz = 1; valid = 1; elem = 55;
        tick(); load_en = 0;
        tick();
        exp = {1'b1, 3'd1, 4'd0, 4'd0, 32'd55, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mid_restart: got %h want %h", obs, exp); end
        valid = 0;
        tick();
        exp = {1'b0, 3'd1, 4'd0, 4'd0, 32'd55, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mid_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_ignore_start();
        @(negedge clk); load_en = 1; addr = 1; msz = 2; nsz = 2; valid = 1; elem = 400;
        tick(); load_en = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); elem = 400 + k;
            if (k == 0) begin load_en = 1; addr = 3; msz = 3; nsz = 3; end
            tick(); load_en = 0;
            exp = {1'b1, 3'd1, 4'(k/2), 4'(k%2), 32'(400 + k), (k == 3), 1'b1, (k != 3), 4'd2, 4'd2};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ignore_write%0d: got %h want %h", k, obs, exp); end
        end
        valid = 0;
        tick();
        exp = {1'b0, 3'd1, 4'd1, 4'd1, 32'd403, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ignore_idle: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); load_en = 1; addr = 0; msz = 1; nsz = 2; valid = 1; elem = 500;
        tick(); load_en = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); elem = 500 + k;
            tick();
            exp = {1'b1, 3'd0, 4'd0, 4'(k), 32'(500 + k), (k == 1), 1'b1, (k != 1), 4'd1, 4'd2};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_first%0d: got %h want %h", k, obs, exp); end
        end
        tick();
        exp = {1'b0, 3'd0, 4'd0, 4'd1, 32'd501, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_idle: got %h want %h", obs, exp); end
        @(negedge clk); load_en = 1; addr = 2; msz = 1; nsz = 1; elem = 600;
        tick(); load_en = 0;
        exp = {1'b0, 3'd2, 4'd0, 4'd1, 32'd501, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_restart: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 3'd2, 4'd0, 4'd0, 32'd600, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1};
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_second: got %h want %h", obs, exp); end
        valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
